branch_predictor: RTL

Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, sitting in the Fetch stage. Each cycle it predicts the next PC for the fetched instruction. It learns from the resolution information the Execute stage produces for every branch, JAL and JALR. It also keeps resolve and mispredict performance counters.

---
 rtl/branch_predictor.sv | 112 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters for the Fetch stage.
// Predicts the next PC combinationally and learns from Execute-stage resolutions.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        prediction_valid,
    output logic [31:0] predicted_pc,
    input  logic        branch_resolve,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_is_branch,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        flush_fetch,
    output logic [31:0] resolve_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_WEAK  = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;
    logic [1:0]       res_ctr;

    // Byte-offset bits carry no information for word-aligned instructions.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{fetch_pc[1:0], resolve_pc[1:0]};

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == CTR_MAX) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Lookup reads stored state only, so a same-cycle update is not visible yet.
    always_comb begin
        fetch_idx        = fetch_pc[IDX_W+1:2];
        fetch_tag        = fetch_pc[31:IDX_W+2];
        fetch_hit        = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        prediction_valid = fetch_hit && ctr_q[fetch_idx][1];
        predicted_pc     = prediction_valid ? target_q[fetch_idx] : fetch_pc + 32'd4;
    end

    always_comb begin
        res_idx = resolve_pc[IDX_W+1:2];
        res_tag = resolve_pc[31:IDX_W+2];
        res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
        res_ctr = ctr_q[res_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (branch_resolve) begin
            if (!resolve_is_branch) begin
                valid_q[res_idx]  <= 1'b1;
                tag_q[res_idx]    <= res_tag;
                target_q[res_idx] <= branch_addr;
                ctr_q[res_idx]    <= CTR_MAX;
            end else if (res_hit) begin
                if (branch_taken) begin
                    ctr_q[res_idx]    <= ctr_inc(res_ctr);
                    target_q[res_idx] <= branch_addr;
                end else begin
                    ctr_q[res_idx] <= ctr_dec(res_ctr);
                end
            end else if (branch_taken) begin
                valid_q[res_idx]  <= 1'b1;
                tag_q[res_idx]    <= res_tag;
                target_q[res_idx] <= branch_addr;
                ctr_q[res_idx]    <= CTR_WEAK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolve_count    <= '0;
            mispredict_count <= '0;
        end else if (branch_resolve) begin
            resolve_count <= resolve_count + 32'd1;
            if (flush_fetch) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule
